even_odd_tally: RTL and testbench

//  Downstream consumer of the 8-bit even/odd checker. Accepts a valid/ready stream of

---
 rtl/even_odd_pkg.sv | 25 ++
 rtl/run_tracker.sv | 52 +++++
 rtl/even_odd_tally.sv | 118 +++++++++++
 tb/tb_even_odd_tally.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/even_odd_pkg.sv
`default_nettype none
// ============================================================================
//  Module : even_odd_pkg
//  Brief  : Shared types and the sample classifier for the even/odd tally.
//  Rev    : 1.0  initial release
// ============================================================================
package even_odd_pkg;

    typedef enum logic [0:0] {
        CLS_EVEN = 1'b0,
        CLS_ODD  = 1'b1
    } cls_t;

    typedef enum logic [0:0] {
        ST_ACCUM  = 1'b0,
        ST_REPORT = 1'b1
    } tally_state_t;

    // The sample LSB is authoritative; the checker flags are only cross-checked.
    function automatic cls_t classify(input logic n0);
        return n0 ? CLS_ODD : CLS_EVEN;
    endfunction

endpackage
`default_nettype wire

// File: rtl/run_tracker.sv
`default_nettype none
// ============================================================================
//  Module : run_tracker
//  Brief  : Tracks the current and longest run of same-class samples.
//  Rev    : 1.0  initial release
// ============================================================================
module run_tracker
    import even_odd_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             step,
    input  cls_t             cls,
    output logic [CNT_W-1:0] cur_run,
    output logic [CNT_W-1:0] max_run
);

    logic [CNT_W-1:0] r_cur_run;
    logic [CNT_W-1:0] r_max_run;
    cls_t             r_prev_cls;
    logic [CNT_W-1:0] w_next_run;

    // A zero current run marks the first sample of a window.
    always_comb begin
        w_next_run = CNT_W'(1);
        if (r_cur_run != '0 && cls == r_prev_cls) begin
            w_next_run = r_cur_run + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cur_run  <= '0;
            r_max_run  <= '0;
            r_prev_cls <= CLS_EVEN;
        end else if (step) begin
            r_cur_run  <= w_next_run;
            r_prev_cls <= cls;
            if (w_next_run > r_max_run) begin
                r_max_run <= w_next_run;
            end
        end
    end

    assign cur_run = r_cur_run;
    assign max_run = r_max_run;

endmodule
`default_nettype wire

// File: rtl/even_odd_tally.sv
`default_nettype none
// ============================================================================
//  Module : even_odd_tally
//  Brief  : Tallies a window of even/odd samples and emits one report per window.
//  Rev    : 1.0  initial release
// ============================================================================
module even_odd_tally
    import even_odd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 16,
    parameter int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] n,
    input  logic             even,
    input  logic             odd,
    output logic             rep_valid,
    input  logic             rep_ready,
    output logic [CNT_W-1:0] even_cnt,
    output logic [CNT_W-1:0] odd_cnt,
    output logic [CNT_W-1:0] max_run,
    output logic             mismatch
);

    tally_state_t     r_state;
    logic [CNT_W-1:0] r_samp_cnt;
    logic [CNT_W-1:0] r_even_cnt;
    logic [CNT_W-1:0] r_odd_cnt;
    logic             r_mismatch;
    logic             r_rep_valid;

    logic             w_accept;
    logic             w_fire;
    logic             w_last;
    logic             w_bad_flags;
    cls_t             w_cls;
    logic [CNT_W-1:0] w_unused_cur_run;
    logic             w_unused_n;

    assign in_ready    = (r_state == ST_ACCUM);
    assign w_accept    = in_valid && in_ready;
    assign w_fire      = r_rep_valid && rep_ready;
    assign w_last      = (r_samp_cnt == CNT_W'(WINDOW - 1));
    assign w_cls       = classify(n[0]);
    assign w_bad_flags = ({even, odd} != {~n[0], n[0]});
    assign w_unused_n  = ^n[WIDTH-1:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ACCUM;
            r_samp_cnt  <= '0;
            r_even_cnt  <= '0;
            r_odd_cnt   <= '0;
            r_mismatch  <= 1'b0;
            r_rep_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        if (w_cls == CLS_ODD) begin
                            r_odd_cnt <= r_odd_cnt + CNT_W'(1);
                        end else begin
                            r_even_cnt <= r_even_cnt + CNT_W'(1);
                        end
                        if (w_bad_flags) begin
                            r_mismatch <= 1'b1;
                        end
                        if (w_last) begin
                            r_samp_cnt  <= '0;
                            r_state     <= ST_REPORT;
                            r_rep_valid <= 1'b1;
                        end else begin
                            r_samp_cnt <= r_samp_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_REPORT: begin
                    // Tallies clear together with the handshake so the next window starts fresh.
                    if (w_fire) begin
                        r_state     <= ST_ACCUM;
                        r_rep_valid <= 1'b0;
                        r_samp_cnt  <= '0;
                        r_even_cnt  <= '0;
                        r_odd_cnt   <= '0;
                        r_mismatch  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_ACCUM;
                    r_rep_valid <= 1'b0;
                end
            endcase
        end
    end

    run_tracker #(
        .CNT_W (CNT_W)
    ) u_run_tracker (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_fire),
        .step    (w_accept),
        .cls     (w_cls),
        .cur_run (w_unused_cur_run),
        .max_run (max_run)
    );

    assign rep_valid = r_rep_valid;
    assign even_cnt  = r_even_cnt;
    assign odd_cnt   = r_odd_cnt;
    assign mismatch  = r_mismatch;

endmodule
`default_nettype wire

// File: tb/tb_even_odd_tally.sv
`default_nettype none
// ============================================================================
//  Module : tb_even_odd_tally
//  Brief  : Directed self-checking bench for even_odd_tally (WINDOW = 16).
//  Rev    : 1.0  initial release
// ============================================================================
module tb_even_odd_tally;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] n = 8'd0;
    logic       even = 1'b0;
    logic       odd = 1'b0;
    logic       rep_valid;
    logic       rep_ready = 1'b0;
    logic [4:0] even_cnt;
    logic [4:0] odd_cnt;
    logic [4:0] max_run;
    logic       mismatch;

    int checks = 0;
    int errors = 0;

    even_odd_tally #(
        .WIDTH  (8),
        .WINDOW (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .n         (n),
        .even      (even),
        .odd       (odd),
        .rep_valid (rep_valid),
        .rep_ready (rep_ready),
        .even_cnt  (even_cnt),
        .odd_cnt   (odd_cnt),
        .max_run   (max_run),
        .mismatch  (mismatch)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample with explicit flags; returns once it has been accepted.
    task automatic send(input logic [7:0] v, input logic e, input logic o);
        int waited;
        waited = 0;
        n = v; even = e; odd = o; in_valid = 1'b1;
        while (!in_ready && waited < 100) begin
            tick();
            waited++;
        end
        if (!in_ready) check("send_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_good(input logic [7:0] v);
        send(v, ~v[0], v[0]);
    endtask

    task automatic expect_report(input string tag, input int e, input int o, input int r, input int m);
        int waited;
        waited = 0;
        while (!rep_valid && waited < 100) begin
            tick();
            waited++;
        end
        check({tag, "_valid"}, int'(rep_valid), 1);
        check({tag, "_even"}, int'(even_cnt), e);
        check({tag, "_odd"}, int'(odd_cnt), o);
        check({tag, "_run"}, int'(max_run), r);
        check({tag, "_mm"}, int'(mismatch), m);
        rep_ready = 1'b1;
        tick();
        rep_ready = 1'b0;
        check({tag, "_clr_valid"}, int'(rep_valid), 0);
        check({tag, "_clr_ready"}, int'(in_ready), 1);
        check({tag, "_clr_cnt"}, int'(even_cnt) + int'(odd_cnt) + int'(max_run) + int'(mismatch), 0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_rep_valid", int'(rep_valid), 0);
        check("rst_counts", int'(even_cnt) + int'(odd_cnt) + int'(max_run) + int'(mismatch), 0);

        // 1: alternating 0..15, report visible right after the 16th accept
        for (int i = 0; i < 16; i++) send_good(8'(i));
        check("t1_latency", int'(rep_valid), 1);
        check("t1_in_ready", int'(in_ready), 0);
        expect_report("t1", 8, 8, 1, 0);

        // 2: runs of 4 even, 8 odd, 4 even
        begin
            logic [7:0] seq [16] = '{8'd2, 8'd4, 8'd6, 8'd8, 8'd3, 8'd5, 8'd7, 8'd9,
                                     8'd11, 8'd13, 8'd15, 8'd1, 8'd10, 8'd12, 8'd14, 8'd16};
            for (int i = 0; i < 16; i++) send_good(seq[i]);
        end

        // 3: backpressure holds the report and blocks input
        n = 8'd5; even = 1'b0; odd = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_in_ready", int'(in_ready), 0);
            check("t3_stable", {27'd0, even_cnt} * 1024 + {27'd0, odd_cnt} * 32 + {27'd0, max_run}, 8 * 1024 + 8 * 32 + 8);
        end
        in_valid = 1'b0;
        expect_report("t2", 8, 8, 8, 0);

        // 4: odd sample carrying even flags sets mismatch, still counted odd
        send(8'd3, 1'b1, 1'b0);
        for (int i = 1; i < 16; i++) send_good(8'(2 * i));
        expect_report("t4", 15, 1, 15, 1);

        // 5: reset after 10 accepts discards the partial window; stray rep_ready ignored
        for (int i = 0; i < 10; i++) send_good(8'(i + 1));
        rep_ready = 1'b1;
        tick();
        rep_ready = 1'b0;
        check("t5_ignore_rdy", int'(even_cnt) * 32 + int'(odd_cnt), 5 * 32 + 5);
        check("t5_no_rep", int'(rep_valid), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_cnt", int'(even_cnt) + int'(odd_cnt) + int'(max_run), 0);
        for (int i = 0; i < 16; i++) send_good(8'(4 * i));
        expect_report("t5", 16, 0, 16, 0);

        // 6: runs of four with ~30% idle cycles, two windows
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 16; i++) begin
                while ($urandom_range(0, 9) < 3) tick();
                send_good(8'(2 * i + ((i >> 2) & 1)));
                if (i == 14) check("t6_early", int'(rep_valid), 0);
            end
            expect_report("t6", 8, 8, 4, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
